multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Sequencer for the multicycle MIPS32 core variant. One shared memory port, one ALU and the IR/PC registers are reused across the cycles of each instruction.
- A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback.
- It drives all datapath strobes and mux selects, and stalls on a memory ready handshake.
- Instruction set: R-type, addi, slti, andi, ori, xori, lw, sw, beq, bne, j.

Parameters:
- TIMEOUT_CYCLES, 255: consecutive cycles a memory access may wait for mem_ready before the FSM traps. 0 disables the timeout.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory has completed the current read or write
- pc_write  out  1  unconditional PC load
- pc_write_eq  out  1  PC load if ALU zero
- pc_write_ne  out  1  PC load if ALU not zero
- pc_source  out  2  PC mux: 00 ALU result, 01 ALUOut register, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  destination register: 1 rd, 0 rt
- reg_write  out  1  register file write
- mem_to_reg  out  1  writeback mux: 1 MDR, 0 ALUOut
- alu_src_a  out  1  ALU A: 0 PC, 1 rs
- alu_src_b  out  2  ALU B: 00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 decode funct, 11 decode opcode
- ext_op  out  1  immediate extension: 1 sign, 0 zero
- instr_done  out  1  one-cycle pulse when an instruction retires
- trap  out  1  sticky; set on illegal opcode or memory timeout
- state  out  4  current state, for debug and verification

Behaviour:
State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, TRAP=12.

Reset:
- While rst=1: state<=FETCH, wait counter<=0, trap<=0, opcode latch<=0. All outputs are forced to 0, including pc_source, alu_src_b and alu_op = 00.
- The first mem_read=1 appears in the first cycle after rst falls.
- rst asserted mid-instruction aborts the instruction with no further strobes.

Any output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - Mealy outputs: ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00, ext_op=1 (precomputes the branch target).
  - Latches opcode into an internal register; all later states use the latched value.
  - Next state: 000000 EXEC_R; lw/sw MEM_ADDR; beq/bne BRANCH; 000010 JUMP; addi/slti/andi/ori/xori EXEC_I; any other opcode TRAP.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00, ext_op=1.
  - Next state: lw MEM_RD, sw MEM_WR.
- MEM_RD:
  - Outputs: mem_read=1, i_or_d=1.
  - Next state: MEM_WB on mem_ready.
- MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
  - Next state: FETCH.
- MEM_WR:
  - Outputs: mem_write=1, i_or_d=1.
  - On mem_ready: instr_done=1 (Mealy), next state FETCH.
- EXEC_R:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state: R_WB.
- R_WB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0, and the EXEC_R ALU selects held.
  - Also instr_done=1. Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_write_eq=1 for beq, pc_write_ne=1 for bne. Also instr_done=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10, instr_done=1.
  - Next state: FETCH.
- EXEC_I:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=11.
  - ext_op=1 for addi/slti, 0 for andi/ori/xori.
  - Next state: I_WB.
- I_WB:
  - Outputs: EXEC_I selects held, reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - Next state: FETCH.
- TRAP:
  - All strobes 0, trap=1. Left only by reset.

Memory wait counter:
- In FETCH, MEM_RD and MEM_WR, the counter increments each cycle that mem_ready=0. It clears on mem_ready=1 and on any state change.
- With TIMEOUT_CYCLES>0, the counter reaching TIMEOUT_CYCLES while mem_ready=0 sends the FSM to TRAP next cycle.
- mem_ready=1 in that same cycle takes priority: the access completes normally.
- The counter saturates and does not wrap.

mem_ready outside FETCH/MEM_RD/MEM_WR is ignored. mem_read and mem_write are never 1 simultaneously.

Instruction latency with mem_ready tied to 1:
- R/I-type: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- beq/bne/j: 3 cycles.

Test Plan:
- mem_ready=1, R-type (000000) → state sequence 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. instr_done pulses once; the next fetch starts on cycle 5.
- lw with mem_ready low for 3 cycles in MEM_RD → state holds 3 for 4 cycles with mem_read=1, i_or_d=1, then 4 with mem_to_reg=1, reg_write=1. Total 8 cycles.
- andi vs addi → ext_op=0 in EXEC_I for andi; 1 for addi; alu_op=11 and alu_src_b=10 in both.
- bne then j → BRANCH: pc_write_ne=1, pc_write_eq=0, alu_op=01, pc_source=01. JUMP: pc_write=1, pc_source=10. 3 cycles each.
- Opcode 111111 → DECODE→TRAP, trap=1 sticky, no strobes for 20 cycles. rst=1 for one cycle → state=0, trap=0, mem_read=1 the following cycle.
- TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH → TRAP after 5 cycles in FETCH. Repeat with mem_ready=1 on the 5th cycle → DECODE, no trap.

Source files
------------

// File: rtl/multicycle_control.sv
// Control sequencer for the multicycle MIPS32 core: a Moore FSM that drives every datapath
// strobe, plus a few Mealy terms gated by the memory ready handshake.
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_eq_o,
    output logic       pc_write_ne_o,
    output logic [1:0] pc_source_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       ext_op_o,
    output logic       instr_done_o,
    output logic       trap_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StExecI   = 4'd10,
        StIWb     = 4'd11,
        StTrap    = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0a;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trap_q;
    logic [5:0]       op_q;
    logic             mem_state;
    logic             timeout;

    assign mem_state = state_q inside {StFetch, StMemRd, StMemWr};
    // A ready in the same cycle as the limit wins over the timeout.
    assign timeout   = (TIMEOUT_CYCLES != 0) && mem_state && !mem_ready_i && (cnt_q >= TimeoutCnt);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:   if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (opcode_i)
                    OpRtype:                             state_d = StExecR;
                    OpLw, OpSw:                          state_d = StMemAddr;
                    OpBeq, OpBne:                        state_d = StBranch;
                    OpJ:                                 state_d = StJump;
                    OpAddi, OpSlti, OpAndi, OpOri, OpXori: state_d = StExecI;
                    default:                             state_d = StTrap;
                endcase
            end
            StMemAddr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready_i) state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   if (mem_ready_i) state_d = StFetch;
            StExecR:   state_d = StRWb;
            StRWb:     state_d = StFetch;
            StBranch:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StExecI:   state_d = StIWb;
            StIWb:     state_d = StFetch;
            default:   state_d = StTrap;
        endcase
        if (timeout) state_d = StTrap;
    end

    always_comb begin
        cnt_d = '0;
        if (mem_state && !mem_ready_i && state_d == state_q) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_d == StTrap) trap_q <= 1'b1;
            if (state_q == StDecode) op_q <= opcode_i;
        end
    end

    assign state_o = rst_i ? 4'd0 : state_q;
    assign trap_o  = trap_q & ~rst_i;

    always_comb begin
        pc_write_o    = 1'b0;
        pc_write_eq_o = 1'b0;
        pc_write_ne_o = 1'b0;
        pc_source_o   = 2'b00;
        i_or_d_o      = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        reg_dst_o     = 1'b0;
        reg_write_o   = 1'b0;
        mem_to_reg_o  = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        alu_op_o      = 2'b00;
        ext_op_o      = 1'b0;
        instr_done_o  = 1'b0;
        if (!rst_i) begin
            case (state_q)
                StFetch: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                StDecode: begin
                    alu_src_b_o = 2'b11;
                    ext_op_o    = 1'b1;
                end
                StMemAddr: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    ext_op_o    = 1'b1;
                end
                StMemRd: begin
                    mem_read_o = 1'b1;
                    i_or_d_o   = 1'b1;
                end
                StMemWb: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    instr_done_o = 1'b1;
                end
                StMemWr: begin
                    mem_write_o  = 1'b1;
                    i_or_d_o     = 1'b1;
                    instr_done_o = mem_ready_i;
                end
                StExecR, StRWb: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 2'b10;
                    if (state_q == StRWb) begin
                        reg_write_o  = 1'b1;
                        reg_dst_o    = 1'b1;
                        instr_done_o = 1'b1;
                    end
                end
                StBranch: begin
                    alu_src_a_o   = 1'b1;
                    alu_op_o      = 2'b01;
                    pc_source_o   = 2'b01;
                    pc_write_eq_o = (op_q == OpBeq);
                    pc_write_ne_o = (op_q == OpBne);
                    instr_done_o  = 1'b1;
                end
                StJump: begin
                    pc_write_o   = 1'b1;
                    pc_source_o  = 2'b10;
                    instr_done_o = 1'b1;
                end
                StExecI, StIWb: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    alu_op_o    = 2'b11;
                    ext_op_o    = (op_q == OpAddi) || (op_q == OpSlti);
                    if (state_q == StIWb) begin
                        reg_write_o  = 1'b1;
                        instr_done_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
